store_strided: RTL and testbench

Vector-buffer-to-DRAM store engine: the 2-D, wide-beat successor to the single-element store unit. It reads tiles from the shared vector buffer file and writes `rows` rows of `length` elements each to DRAM, spaced `row_stride` bytes apart. Writes go out `BEAT_ELEMS` elements per beat through a valid/ready memory port with byte enables. It sits between the instruction decoder's STORE dispatch and the DRAM arbiter.

---
 rtl/store_strided.sv | 195 +++++++++++++++++++
 tb/tb_store_strided.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_strided.sv
// ============================================================================
// Module   : store_strided
// Purpose  : 2-D strided store engine, vector buffer tiles -> DRAM write beats
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_strided #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
    parameter int BEAT_ELEMS = 4,
    parameter int LEN_WIDTH  = 10,
    parameter int ROWS_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            dram_addr,
    input  logic [LEN_WIDTH-1:0]             length,
    input  logic [ROWS_WIDTH-1:0]            rows,
    input  logic [ADDR_WIDTH-1:0]            row_stride,
    input  logic [4:0]                       buf_id,
    output logic                             busy,
    output logic                             done,
    output logic                             buf_read_en,
    output logic [4:0]                       buf_read_id,
    input  logic [TILE_WIDTH-1:0]            buf_read_data,
    input  logic                             buf_read_done,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BEAT_ELEMS*DATA_WIDTH-1:0] mem_wdata,
    output logic [BEAT_ELEMS-1:0]            mem_be,
    input  logic                             mem_ready,
    output logic                             mem_flush
);

    localparam int NBEATS = TILE_ELEMS / BEAT_ELEMS;
    localparam int KW     = $clog2(NBEATS + 1);
    localparam int OW     = LEN_WIDTH + 1;
    localparam int BEAT_W = BEAT_ELEMS * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WRITE   = 3'd2,
        S_ROW_ADV = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [LEN_WIDTH-1:0]  r_length;
    logic [ROWS_WIDTH-1:0] r_rows_left;
    logic [OW-1:0]         r_tile_off;
    logic [KW-1:0]         r_k;
    logic [TILE_WIDTH-1:0] r_tile;

    logic [OW-1:0]         w_len_ext;
    logic [OW-1:0]         w_elem;
    logic                  w_beat_valid;
    logic                  w_row_more;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_empty_cmd;
    logic [BEAT_ELEMS-1:0] w_be;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BEAT_W-1:0]     w_wdata;

    // w_elem: element offset within the row of the beat about to be presented
    assign w_len_ext    = {1'b0, r_length};
    assign w_elem       = r_tile_off + (OW'(r_k) * OW'(BEAT_ELEMS));
    assign w_beat_valid = (r_k < KW'(NBEATS)) && (w_elem < w_len_ext);
    assign w_row_more   = (r_tile_off + OW'(TILE_ELEMS)) < w_len_ext;
    assign w_slot_free  = !mem_we || mem_ready;
    assign w_accept     = (r_state == S_IDLE) && start && !busy;
    assign w_empty_cmd  = (length == '0) || (rows == '0);
    assign w_addr       = r_row_base + ADDR_WIDTH'(w_elem);
    assign w_wdata      = r_tile[int'(r_k)*BEAT_W +: BEAT_W];

    for (genvar j = 0; j < BEAT_ELEMS; j++) begin : g_be
        assign w_be[j] = (w_elem + OW'(j)) < w_len_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_empty_cmd ? S_FINISH : S_REQ;
                end
            end
            S_REQ: begin
                if (buf_read_done) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_slot_free && !w_beat_valid) begin
                    if (w_row_more) begin
                        w_state_next = S_REQ;
                    end else if (r_rows_left != ROWS_WIDTH'(1)) begin
                        w_state_next = S_ROW_ADV;
                    end else begin
                        w_state_next = S_FINISH;
                    end
                end
            end
            S_ROW_ADV: w_state_next = S_REQ;
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_flush   <= 1'b0;
            buf_read_en <= 1'b0;
            buf_read_id <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            done        <= 1'b0;
            mem_flush   <= 1'b0;
            buf_read_en <= (w_state_next == S_REQ);
            case (r_state)
                S_IDLE: begin
                    // busy stays high through the done cycle, dropping one edge later
                    if (w_accept) begin
                        busy        <= 1'b1;
                        buf_read_id <= buf_id;
                        r_row_base  <= dram_addr;
                        r_stride    <= row_stride;
                        r_length    <= length;
                        r_rows_left <= rows;
                        r_tile_off  <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (buf_read_done) begin
                        r_tile <= buf_read_data;
                        r_k    <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_slot_free) begin
                        if (w_beat_valid) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= w_addr;
                            mem_wdata <= w_wdata;
                            mem_be    <= w_be;
                            r_k       <= r_k + KW'(1);
                        end else begin
                            mem_we <= 1'b0;
                            if (w_row_more) begin
                                r_tile_off <= r_tile_off + OW'(TILE_ELEMS);
                            end
                        end
                    end
                end
                S_ROW_ADV: begin
                    r_row_base  <= r_row_base + r_stride;
                    r_tile_off  <= '0;
                    r_rows_left <= r_rows_left - ROWS_WIDTH'(1);
                end
                S_FINISH: begin
                    done      <= 1'b1;
                    mem_flush <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_strided.sv
// ============================================================================
// Module   : tb_store_strided
// Purpose  : Self-checking bench for store_strided against a row/tile model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_strided;

    localparam int AW = 24;
    localparam int LW = 10;
    localparam int RW = 8;
    localparam int TW = 256;
    localparam int TE = 32;
    localparam int BE = 4;
    localparam int BUDGET = 5000;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] dram_addr;
    logic [LW-1:0] length;
    logic [RW-1:0] rows;
    logic [AW-1:0] row_stride;
    logic [4:0]    buf_id;
    logic          busy;
    logic          done;
    logic          buf_read_en;
    logic [4:0]    buf_read_id;
    logic [TW-1:0] buf_read_data;
    logic          buf_read_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic          mem_flush;

    always #5 clk = ~clk;

    store_strided dut (
        .clk(clk), .rst(rst), .start(start), .dram_addr(dram_addr),
        .length(length), .rows(rows), .row_stride(row_stride), .buf_id(buf_id),
        .busy(busy), .done(done), .buf_read_en(buf_read_en), .buf_read_id(buf_read_id),
        .buf_read_data(buf_read_data), .buf_read_done(buf_read_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_flush(mem_flush)
    );

    beat_t       act_q[$];
    logic [255:0] tile_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   ready_mode = 0;
    int   stall_left = 0;
    int   rd_rand = 0;
    int   rd_wait = 0;
    int   done_cnt = 0;
    int   flush_cnt = 0;
    int   en_cyc = 0;
    int   we_cyc = 0;
    logic [4:0] exp_id = '0;
    logic  hold_valid;
    beat_t hold_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_tile();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Environment: buffer responder, memory ready, beat/tile capture, stall hold check
    initial begin
        buf_read_done = 1'b0;
        buf_read_data = '0;
        mem_ready     = 1'b0;
        hold_valid    = 1'b0;
        hold_beat     = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mem_flush) flush_cnt++;
            if (done || mem_flush) chk("flush_with_done", mem_flush, done);
            if (buf_read_en) begin
                en_cyc++;
                chk("read_id", buf_read_id, exp_id);
            end
            if (mem_we) we_cyc++;
            if (hold_valid && !rst)
                chk("stall_hold", {mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, hold_beat});
            if (buf_read_done) begin
                buf_read_done = 1'b0;
            end else if (buf_read_en && !rst) begin
                if (rd_wait == 0) begin
                    buf_read_data = rand_tile();
                    buf_read_done = 1'b1;
                    rd_wait = (rd_rand != 0) ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    rd_wait--;
                end
            end
            case (ready_mode)
                1: mem_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (mem_we && act_q.size() == 1 && stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
                3: mem_ready = 1'b0;
                default: mem_ready = 1'b1;
            endcase
            if (mem_we && mem_ready) act_q.push_back({mem_addr, mem_wdata, mem_be});
            if (buf_read_en && buf_read_done) tile_q.push_back(buf_read_data);
            hold_valid = mem_we && !mem_ready;
            hold_beat  = {mem_addr, mem_wdata, mem_be};
        end
    end

    // Issue one command, wait for done, then compare the captured trace to the model
    task automatic run_cmd(input logic [23:0] a, input int len, input int nrows,
                           input logic [23:0] str, input logic [4:0] id,
                           input int collide, output int lat);
        beat_t        exp_q[$];
        beat_t        b;
        logic [255:0] t;
        int           tpr;
        int           ntiles;
        int           off;
        act_q.delete();
        tile_q.delete();
        done_cnt = 0; flush_cnt = 0; en_cyc = 0; we_cyc = 0; rd_wait = 0;
        exp_id = id;
        @(negedge clk);
        dram_addr = a; length = LW'(len); rows = RW'(nrows); row_stride = str; buf_id = id;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk("busy_after_start", busy, 1);
        dram_addr = 24'($urandom); length = LW'($urandom); rows = RW'($urandom);
        row_stride = 24'($urandom); buf_id = 5'($urandom);
        while (!done && lat < BUDGET) begin
            start = (collide != 0 && lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", lat < BUDGET, 1);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("single_done", {done_cnt[15:0], flush_cnt[15:0]}, {16'd1, 16'd1});

        tpr = (len + TE - 1) / TE;
        ntiles = (len == 0 || nrows == 0) ? 0 : nrows * tpr;
        for (int r = 0; r < nrows && len > 0; r++) begin
            for (int ti = 0; ti < tpr; ti++) begin
                t = (r * tpr + ti < tile_q.size()) ? tile_q[r * tpr + ti] : '0;
                for (int k = 0; k < TE / BE; k++) begin
                    off = ti * TE + k * BE;
                    if (off < len) begin
                        b.addr = a + 24'(r) * str + 24'(off);
                        b.data = t[k*32 +: 32];
                        for (int j = 0; j < BE; j++) b.be[j] = (off + j < len);
                        exp_q.push_back(b);
                    end
                end
            end
        end
        chk("tile_reads", tile_q.size(), ntiles);
        chk("beat_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk($sformatf("beat%0d", i), act_q[i], exp_q[i]);
    endtask

    int lat0, lat1;
    logic [23:0] exp_addr;

    initial begin
        rst = 1'b1; start = 1'b0; dram_addr = '0; length = '0; rows = '0;
        row_stride = '0; buf_id = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, buf_read_en, buf_read_id, mem_we, mem_be, mem_flush}, 0);
        chk("reset_data", {mem_addr, mem_wdata}, 0);
        rst = 1'b0;

        // Single row, partial beat
        ready_mode = 0;
        run_cmd(24'h000100, 6, 1, 24'h0, 5'd3, 0, lat0);
        chk("t1_beats", act_q.size(), 2);
        chk("t1_b0", {act_q[0].addr, act_q[0].be}, {24'h000100, 4'b1111});
        chk("t1_b1", {act_q[1].addr, act_q[1].be}, {24'h000104, 4'b0011});
        chk("t1_reads", en_cyc > 0 && tile_q.size() == 1, 1);

        // Multi-tile row
        run_cmd(24'h001000, 40, 1, 24'h0, 5'd7, 0, lat0);
        chk("t2_beats", act_q.size(), 10);
        chk("t2_last", {act_q[9].addr, act_q[9].be}, {24'h001024, 4'b1111});
        chk("t2_tile2", act_q[8].addr, 24'h001020);

        // 2-D stride
        run_cmd(24'h000200, 8, 3, 24'h40, 5'd1, 0, lat0);
        chk("t3_beats", act_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            exp_addr = 24'h200 + 24'(i / 2) * 24'h40 + 24'(i % 2) * 24'd4;
            chk($sformatf("t3_addr%0d", i), act_q[i].addr, exp_addr);
        end

        // Backpressure: 5-cycle stall on the second beat
        rd_rand = 0;
        ready_mode = 0;
        run_cmd(24'h000300, 16, 1, 24'h0, 5'd2, 0, lat0);
        ready_mode = 2;
        stall_left = 5;
        run_cmd(24'h000300, 16, 1, 24'h0, 5'd2, 0, lat1);
        chk("stall_delay", lat1 - lat0, 5);
        ready_mode = 0;

        // Degenerate commands
        run_cmd(24'h000400, 0, 3, 24'h10, 5'd4, 0, lat0);
        chk("len0_latency", lat0, 2);
        chk("len0_no_traffic", {en_cyc[15:0], we_cyc[15:0]}, 0);
        run_cmd(24'h000400, 5, 0, 24'h10, 5'd4, 0, lat0);
        chk("rows0_latency", lat0, 2);
        chk("rows0_no_traffic", {en_cyc[15:0], we_cyc[15:0]}, 0);

        // start while busy is ignored
        rd_rand = 1;
        run_cmd(24'h000800, 50, 2, 24'h100, 5'd9, 1, lat0);

        // Reset during a stalled beat
        ready_mode = 3;
        exp_id = 5'd6;
        @(negedge clk);
        dram_addr = 24'h000500; length = 10'd8; rows = 8'd1; row_stride = '0; buf_id = 5'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !mem_we; i++) @(negedge clk);
        chk("rst_we_seen", mem_we, 1);
        @(negedge clk);
        done_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {busy, done, buf_read_en, buf_read_id, mem_we, mem_be, mem_flush}, 0);
        chk("rst_mid_data", {mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        run_cmd(24'h000600, 12, 2, 24'h20, 5'd11, 0, lat0);

        // Address wrap
        run_cmd(24'hFFFFFC, 8, 1, 24'h0, 5'd5, 0, lat0);
        chk("wrap_b0", act_q[0].addr, 24'hFFFFFC);
        chk("wrap_b1", act_q[1].addr, 24'h000000);

        // Randomized commands with random ready and read latency
        ready_mode = 1;
        rd_rand = 1;
        for (int n = 0; n < 8; n++)
            run_cmd(24'($urandom), int'($urandom_range(1, 100)), int'($urandom_range(1, 4)),
                    24'($urandom), 5'($urandom), 0, lat0);
        run_cmd(24'($urandom), 1023, 1, 24'h0, 5'd31, 0, lat0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
